// File: rtl/quad_step_decoder_pkg.sv
// Shared types and helpers for the quadrature step decoder: Gray-ordered
// phase states, direction encoding and the phase-move helpers.
package quad_step_decoder_pkg;

  // Gray order S00 -> S01 -> S11 -> S10 -> S00 counts up.
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } phase_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic phase_e gray_next(input phase_e s);
    case (s)
      S00:     return S01;
      S01:     return S11;
      S11:     return S10;
      default: return S00;
    endcase
  endfunction

  // True when exactly one of the two phase bits differs.
  function automatic logic one_bit_move(input logic [1:0] x, input logic [1:0] y);
    return ^(x ^ y);
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Signal bundle between the encoder front end and its user.
// en qualifies every sampling edge (no handshake back-pressure); step is a
// single-cycle pulse, up/err/phase are levels valid whenever rst is high.
interface quad_step_decoder_if;
  logic       en;
  logic       a_in;
  logic       b_in;
  logic       err_clr;
  logic       step;
  logic       up;
  logic       err;
  logic [1:0] phase;

  modport master (
    output en, a_in, b_in, err_clr,
    input  step, up, err, phase
  );

  modport slave (
    input  en, a_in, b_in, err_clr,
    output step, up, err, phase
  );
endinterface

// File: rtl/quad_step_decoder_glitch_filter.sv
// One encoder channel: 2-flop synchronizer followed by a stability filter
// that accepts a new level only after FILT consecutive enabled cycles.
module quad_step_decoder_glitch_filter #(
  parameter int FILT = 3,
  parameter int FW   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pin,
  output logic filt
);

  localparam logic [FW-1:0] LAST = FW'(FILT - 1);

  logic          sync1;
  logic          sync2;
  logic [FW-1:0] cnt;

  // Synchronizer runs freely so the pin is never sampled raw, even while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (en) begin
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + FW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: filtered channels feed a Gray-phase tracker that
// emits a registered step pulse, a held direction and a sticky error flag.
module quad_step_decoder
  import quad_step_decoder_pkg::*;
#(
  parameter int FILT = 3,
  parameter int FW   = 2,
  parameter bit X4   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  quad_step_decoder_if.slave bus
);

  logic       filt_a;
  logic       filt_b;
  logic [1:0] filt_ab;

  phase_e state;
  phase_e state_nx;
  logic   step_q, step_nx;
  logic   up_q,   up_nx;
  logic   err_q,  err_nx;

  quad_step_decoder_glitch_filter #(.FILT(FILT), .FW(FW)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .pin  (bus.a_in),
    .filt (filt_a)
  );

  quad_step_decoder_glitch_filter #(.FILT(FILT), .FW(FW)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .pin  (bus.b_in),
    .filt (filt_b)
  );

  assign filt_ab = {filt_a, filt_b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S00;
      step_q <= 1'b0;
      up_q   <= DIR_UP;
      err_q  <= 1'b0;
    end else if (bus.en) begin
      state  <= state_nx;
      step_q <= step_nx;
      up_q   <= up_nx;
      err_q  <= err_nx;
    end else begin
      step_q <= 1'b0;
    end
  end

  // A new illegal move overrides err_clr in the same cycle.
  always_comb begin
    state_nx = state;
    step_nx  = 1'b0;
    up_nx    = up_q;
    err_nx   = err_q & ~bus.err_clr;
    if (filt_ab != state) begin
      state_nx = phase_e'(filt_ab);
      if (one_bit_move(filt_ab, state)) begin
        up_nx   = (filt_ab == gray_next(state)) ? DIR_UP : DIR_DN;
        step_nx = X4 ? 1'b1 : (filt_ab == S00);
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  assign bus.step  = step_q;
  assign bus.up    = up_q;
  assign bus.err   = err_q;
  assign bus.phase = state;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: X4=1 and X4=0 instances share stimulus and are
// checked every cycle against a position-arithmetic model, plus directed checks.
module tb_quad_step_decoder;

  localparam int FILT = 3;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic en      = 1'b1;
  logic a       = 1'b0;
  logic b       = 1'b0;
  logic err_clr = 1'b0;
  logic chk_on  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int c4 = 0;
  int c1 = 0;
  int base4, base1;

  // Reference model state
  logic [1:0] d1, d2, mf;
  int         run [2];
  logic [1:0] m_ph;
  logic       m_up, m_err, m_st4, m_st1;
  int         delta;

  quad_step_decoder_if bus4 ();
  quad_step_decoder_if bus1 ();

  assign bus4.en = en;  assign bus4.a_in = a;  assign bus4.b_in = b;  assign bus4.err_clr = err_clr;
  assign bus1.en = en;  assign bus1.a_in = a;  assign bus1.b_in = b;  assign bus1.err_clr = err_clr;

  quad_step_decoder #(.FILT(FILT), .FW(2), .X4(1'b1)) dut_x4 (.clk(clk), .rst(rst), .bus(bus4));
  quad_step_decoder #(.FILT(FILT), .FW(2), .X4(1'b0)) dut_x1 (.clk(clk), .rst(rst), .bus(bus1));

  // clock / reset
  always #5 clk = ~clk;

  function automatic int gidx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    {a, b} = ab;
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: pins seen two edges late, accepted after FILT
  // consecutive differing enabled samples; moves judged by Gray position distance.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        d1 = 2'b00; d2 = 2'b00; mf = 2'b00; run[0] = 0; run[1] = 0;
        m_ph = 2'b00; m_up = 1'b1; m_err = 1'b0; m_st4 = 1'b0; m_st1 = 1'b0;
      end else begin
        m_st4 = 1'b0;
        m_st1 = 1'b0;
        if (en) begin
          if (err_clr) m_err = 1'b0;
          delta = (gidx(mf) - gidx(m_ph) + 4) % 4;
          if (delta == 1 || delta == 3) begin
            m_up  = (delta == 1);
            m_st4 = 1'b1;
            m_st1 = (mf == 2'b00);
          end else if (delta == 2) begin
            m_err = 1'b1;
          end
          m_ph = mf;
          for (int ch = 0; ch < 2; ch++) begin
            if (d2[ch] == mf[ch]) run[ch] = 0;
            else if (run[ch] + 1 == FILT) begin
              mf[ch]  = d2[ch];
              run[ch] = 0;
            end else run[ch] = run[ch] + 1;
          end
        end
        d2 = d1;
        d1 = {a, b};
      end
    end
  end

  // scoreboard: every cycle, both instances
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("x4_step",  {1'b0, bus4.step}, {1'b0, m_st4});
        check("x4_up",    {1'b0, bus4.up},   {1'b0, m_up});
        check("x4_err",   {1'b0, bus4.err},  {1'b0, m_err});
        check("x4_phase", bus4.phase,        m_ph);
        check("x1_step",  {1'b0, bus1.step}, {1'b0, m_st1});
        check("x1_up",    {1'b0, bus1.up},   {1'b0, m_up});
        check("x1_err",   {1'b0, bus1.err},  {1'b0, m_err});
        check("x1_phase", bus1.phase,        m_ph);
      end
      if (bus4.step) c4++;
      if (bus1.step) c1++;
    end
  end

  // driver sequence
  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_phase", bus4.phase, 2'b00);
    check("rst_up",    {1'b0, bus4.up},   2'b01);
    check("rst_err",   {1'b0, bus4.err},  2'b00);
    check("rst_step",  {1'b0, bus4.step}, 2'b00);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // forward 00 -> 01 -> 11 -> 10 -> 00
    base4 = c4; base1 = c1;
    {a, b} = 2'b01;
    repeat (5) @(negedge clk);
    check("lat_pre",  {1'b0, bus4.step}, 2'b00);
    @(negedge clk);
    check("lat_step", {1'b0, bus4.step}, 2'b01);
    check("lat_phase", bus4.phase, 2'b01);
    repeat (4) @(negedge clk);
    hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
    check("fwd_cnt4", 2'(c4 - base4), 2'(4));
    check("fwd_cnt1", 2'(c1 - base1), 2'(1));
    check("fwd_up",   {1'b0, bus4.up},  2'b01);
    check("fwd_err",  {1'b0, bus4.err}, 2'b00);
    check("fwd_model_phase", m_ph, 2'b00);
    if (c4 - base4 != 4) begin n_bad++; $display("FAIL fwd_total: got %0d expected 4", c4 - base4); end

    // reverse 00 -> 10 -> 11 -> 01 -> 00
    base4 = c4; base1 = c1;
    hold(2'b10, 10);
    check("rev_up_first", {1'b0, bus4.up}, 2'b00);
    hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    check("rev_cnt4", 2'(c4 - base4), 2'(4));
    check("rev_cnt1", 2'(c1 - base1), 2'(1));
    check("rev_up",   {1'b0, bus1.up}, 2'b00);

    // glitch rejection: 2-cycle pulse dropped, 3-cycle pulse accepted
    base4 = c4;
    hold(2'b10, 2); hold(2'b00, 10);
    check("glitch_cnt",   2'(c4 - base4), 2'(0));
    check("glitch_phase", bus4.phase, 2'b00);
    hold(2'b10, 3); hold(2'b00, 3);
    check("accept_step",  {1'b0, bus4.step}, 2'b01);
    check("accept_phase", bus4.phase, 2'b10);
    repeat (10) @(negedge clk);

    // illegal double transition, clear, clear colliding with a new error
    base4 = c4; base1 = c1;
    hold(2'b11, 10);
    check("ill_err",   {1'b0, bus4.err}, 2'b01);
    check("ill_phase", bus4.phase, 2'b11);
    check("ill_cnt4",  2'(c4 - base4), 2'(0));
    check("ill_cnt1",  2'(c1 - base1), 2'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", {1'b0, bus4.err}, 2'b00);
    hold(2'b00, 5);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_vs_set", {1'b0, bus4.err}, 2'b01);
    check("clr_vs_set_phase", bus4.phase, 2'b00);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // enable gating
    base4 = c4;
    en = 1'b0;
    hold(2'b10, 15);
    check("en_cnt",   2'(c4 - base4), 2'(0));
    check("en_phase", bus4.phase, 2'b00);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("en_pre",  {1'b0, bus4.step}, 2'b00);
    @(negedge clk);
    check("en_step", {1'b0, bus4.step}, 2'b01);
    hold(2'b00, 10);

    // async reset between pin change and acceptance
    base4 = c4;
    hold(2'b01, 2);
    #2 rst = 1'b0;
    @(negedge clk);
    check("arst_step",  {1'b0, bus4.step}, 2'b00);
    check("arst_phase", bus4.phase, 2'b00);
    check("arst_up",    {1'b0, bus4.up},  2'b01);
    check("arst_err",   {1'b0, bus4.err}, 2'b00);
    hold(2'b00, 3);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_cnt", 2'(c4 - base4), 2'(0));

    // pins at 11 across reset read as a double change
    hold(2'b11, 4);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_err",   {1'b0, bus4.err}, 2'b01);
    check("post_rst_phase", bus4.phase, 2'b11);
    hold(2'b01, 10);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // randomized stimulus
    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      err_clr = ($urandom_range(0, 7) == 0);
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 8));
    end
    en = 1'b1;
    err_clr = 1'b0;
    hold(2'b00, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
